// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, default datapath widths and the
// all-zero instruction used to fill pipeline bubbles.
package cpu_pkg;

    localparam int DEFAULT_PC_W    = 16;
    localparam int DEFAULT_INSTR_W = 16;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    localparam logic [DEFAULT_INSTR_W-1:0] NOP_INSTR = {DEFAULT_INSTR_W{1'b0}};

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr wins over inc.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;

    // Next-count selection: clear, saturating increment or hold.
    always_comb begin
        count_nxt_s = count_r;
        if (clr) begin
            count_nxt_s = CNT_ZERO;
        end else if (inc && (count_r != CNT_MAX)) begin
            count_nxt_s = count_r + CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= CNT_ZERO;
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives instruction memory and fills the
// IF/ID register, honouring redirects, stalls and halt.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int              PC_W     = DEFAULT_PC_W,
    parameter int              INSTR_W  = DEFAULT_INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               load_new_pc,
    input  logic [PC_W-1:0]    new_pc,
    input  logic               halt,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    output logic               if_valid,
    output logic [15:0]        redirect_count
);

    localparam logic [PC_W-1:0]    PC_ONE    = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [PC_W-1:0]    PC_ZERO   = {PC_W{1'b0}};
    localparam logic [INSTR_W-1:0] BUBBLE    = INSTR_W'(NOP_INSTR);

    fetch_state_e       state_r;
    fetch_state_e       state_nxt_s;
    logic [PC_W-1:0]    pc_r;
    logic [PC_W-1:0]    pc_nxt_s;
    logic [INSTR_W-1:0] if_instr_r;
    logic [INSTR_W-1:0] if_instr_nxt_s;
    logic [PC_W-1:0]    if_pc_r;
    logic [PC_W-1:0]    if_pc_nxt_s;
    logic               if_valid_r;
    logic               if_valid_nxt_s;
    logic               redirect_s;

    // A redirect is only accepted while running; BOOT and HALTED drop it.
    assign redirect_s = (state_r == ST_RUN) && load_new_pc;

    // Next-state logic; in RUN the priority is redirect, stall, halt, fetch.
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        if_instr_nxt_s = if_instr_r;
        if_pc_nxt_s    = if_pc_r;
        if_valid_nxt_s = if_valid_r;
        case (state_r)
            ST_BOOT: begin
                if_valid_nxt_s = 1'b0;
                state_nxt_s    = ST_RUN;
            end
            ST_RUN: begin
                if (load_new_pc) begin
                    pc_nxt_s       = new_pc;
                    if_instr_nxt_s = BUBBLE;
                    if_valid_nxt_s = 1'b0;
                end else if (stall) begin
                    pc_nxt_s = pc_r;
                end else if (halt && if_valid_r) begin
                    // halt is decoded from IF/ID, so a bubble cannot carry it
                    if_valid_nxt_s = 1'b0;
                    state_nxt_s    = ST_HALTED;
                end else begin
                    if_instr_nxt_s = imem_rdata;
                    if_pc_nxt_s    = pc_r;
                    if_valid_nxt_s = 1'b1;
                    pc_nxt_s       = pc_r + PC_ONE;
                end
            end
            ST_HALTED: begin
                if_valid_nxt_s = 1'b0;
            end
            default: begin
                if_valid_nxt_s = 1'b0;
                state_nxt_s    = ST_BOOT;
            end
        endcase
    end

    // PC, IF/ID register and FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_BOOT;
            pc_r       <= RESET_PC;
            if_instr_r <= BUBBLE;
            if_pc_r    <= PC_ZERO;
            if_valid_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            if_instr_r <= if_instr_nxt_s;
            if_pc_r    <= if_pc_nxt_s;
            if_valid_r <= if_valid_nxt_s;
        end
    end

    sat_counter #(
        .WIDTH (16)
    ) u_redirect_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (redirect_s),
        .count (redirect_count)
    );

    assign imem_addr = pc_r;
    assign if_instr  = if_instr_r;
    assign if_pc     = if_pc_r;
    assign if_valid  = if_valid_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then random traffic against a behavioural model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, load_new_pc, halt;
    logic [15:0] new_pc, imem_addr, imem_rdata, if_instr, if_pc, redirect_count;
    logic        if_valid;

    logic        s_rst, s_stall, s_load, s_halt, s_if_valid;
    logic [3:0]  s_new_pc, s_addr, s_if_pc;
    logic [15:0] s_rdata, s_if_instr, s_count;

    int checks = 0;
    int failures = 0;

    assign imem_rdata = 16'hA000 + imem_addr;
    assign s_rdata    = 16'hA000 + {12'h000, s_addr};

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .load_new_pc(load_new_pc),
        .new_pc(new_pc), .halt(halt), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .if_instr(if_instr), .if_pc(if_pc),
        .if_valid(if_valid), .redirect_count(redirect_count)
    );

    fetch_stage #(.PC_W(4), .INSTR_W(16), .RESET_PC(4'd14)) dut_small (
        .clk(clk), .rst(s_rst), .stall(s_stall), .load_new_pc(s_load),
        .new_pc(s_new_pc), .halt(s_halt), .imem_addr(s_addr),
        .imem_rdata(s_rdata), .if_instr(s_if_instr), .if_pc(s_if_pc),
        .if_valid(s_if_valid), .redirect_count(s_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the main instance: plain integers, rules applied per edge.
    int  m_pc, m_instr, m_ipc, m_cnt;
    bit  m_valid, m_boot, m_halted, model_on = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_pc = 0; m_instr = 0; m_ipc = 0; m_cnt = 0;
            m_valid = 1'b0; m_boot = 1'b1; m_halted = 1'b0; model_on = 1'b1;
        end else if (model_on) begin
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (m_halted) begin
                m_valid = 1'b0;
            end else if (load_new_pc) begin
                m_pc = int'(new_pc); m_valid = 1'b0; m_instr = 0;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end else if (stall) begin
                m_pc = m_pc;
            end else if (halt && m_valid) begin
                m_valid = 1'b0; m_halted = 1'b1;
            end else begin
                m_instr = (32'hA000 + m_pc) & 32'hFFFF;
                m_ipc   = m_pc;
                m_valid = 1'b1;
                m_pc    = (m_pc + 1) & 32'hFFFF;
            end
        end
        #1;
        if (model_on) begin
            check("model_valid", if_valid, m_valid);
            check("model_pc", imem_addr, m_pc);
            check("model_count", redirect_count, m_cnt);
            check("model_instr", if_instr, m_instr);
            if (m_valid) check("model_if_pc", if_pc, m_ipc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; load_new_pc = 1'b0; halt = 1'b0; new_pc = 16'h0000;
        s_rst = 1'b1; s_stall = 1'b0; s_load = 1'b0; s_halt = 1'b0; s_new_pc = 4'h0;

        tick(); tick();
        check("rst_valid", if_valid, 1'b0);
        check("rst_instr", if_instr, 16'h0000);
        check("rst_if_pc", if_pc, 16'h0000);
        check("rst_count", redirect_count, 16'h0000);
        check("rst_addr", imem_addr, 16'h0000);

        // reset release: one BOOT cycle, then sequential fetch
        rst = 1'b0;
        tick();
        check("boot_valid", if_valid, 1'b0);
        check("boot_addr", imem_addr, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("seq_valid", if_valid, 1'b1);
            check("seq_if_pc", if_pc, 16'(i));
            check("seq_instr", if_instr, 16'hA000 + 16'(i));
        end
        tick(); tick();
        check("pc_at_5", imem_addr, 16'h0005);

        // redirect from PC 5 to 0x40
        load_new_pc = 1'b1; new_pc = 16'h0040;
        tick();
        check("redir_bubble", if_valid, 1'b0);
        check("redir_instr", if_instr, 16'h0000);
        check("redir_addr", imem_addr, 16'h0040);
        load_new_pc = 1'b0;
        tick();
        check("redir_valid", if_valid, 1'b1);
        check("redir_if_pc", if_pc, 16'h0040);
        check("redir_first", if_instr, 16'hA040);
        check("redir_count", redirect_count, 16'h0001);

        // stall for three cycles with a redirect in the second
        stall = 1'b1;
        tick();
        check("stall_hold_valid", if_valid, 1'b1);
        check("stall_hold_pc", if_pc, 16'h0040);
        check("stall_hold_addr", imem_addr, 16'h0041);
        load_new_pc = 1'b1; new_pc = 16'h0080;
        tick();
        check("stall_redir_valid", if_valid, 1'b0);
        check("stall_redir_addr", imem_addr, 16'h0080);
        check("stall_redir_count", redirect_count, 16'h0002);
        load_new_pc = 1'b0;
        tick();
        check("stall_after_valid", if_valid, 1'b0);
        check("stall_after_addr", imem_addr, 16'h0080);
        stall = 1'b0;
        tick();
        check("unstall_valid", if_valid, 1'b1);
        check("unstall_instr", if_instr, 16'hA080);

        // halt with a valid instruction; redirects ignored afterwards
        halt = 1'b1;
        tick();
        check("halt_valid", if_valid, 1'b0);
        check("halt_addr", imem_addr, 16'h0081);
        halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            load_new_pc = i[0];
            new_pc = 16'($urandom);
            tick();
            check("halted_addr", imem_addr, 16'h0081);
            check("halted_valid", if_valid, 1'b0);
            check("halted_count", redirect_count, 16'h0002);
        end
        load_new_pc = 1'b0;
        rst = 1'b1;
        tick();
        check("halt_rst_addr", imem_addr, 16'h0000);
        check("halt_rst_count", redirect_count, 16'h0000);
        rst = 1'b0;
        tick();
        check("halt_boot_valid", if_valid, 1'b0);
        tick();
        check("halt_run_if_pc", if_pc, 16'h0000);
        check("halt_run_valid", if_valid, 1'b1);

        // reset in the middle of a stall
        stall = 1'b1;
        tick();
        check("mid_stall_valid", if_valid, 1'b1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", if_valid, 1'b0);
        check("mid_rst_instr", if_instr, 16'h0000);
        check("mid_rst_if_pc", if_pc, 16'h0000);
        check("mid_rst_addr", imem_addr, 16'h0000);
        rst = 1'b0; stall = 1'b0;
        tick();
        check("mid_boot_valid", if_valid, 1'b0);
        check("mid_boot_addr", imem_addr, 16'h0000);
        tick();
        check("mid_run_valid", if_valid, 1'b1);

        // random traffic, checked by the model process
        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom % 48) == 0;
            stall       = ($urandom % 4) == 0;
            load_new_pc = ($urandom % 6) == 0;
            halt        = ($urandom % 24) == 0;
            new_pc      = 16'($urandom);
            tick();
        end
        rst = 1'b0; stall = 1'b0; load_new_pc = 1'b0; halt = 1'b0;

        // narrow PC wrap and counter saturation
        tick();
        s_rst = 1'b0;
        tick();
        check("w_boot_valid", s_if_valid, 1'b0);
        check("w_boot_addr", s_addr, 4'd14);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] epc;
            epc = 4'(14 + i);
            tick();
            check("w_if_pc", s_if_pc, epc);
            check("w_instr", s_if_instr, 16'hA000 + {12'h000, epc});
            check("w_valid", s_if_valid, 1'b1);
        end
        s_load = 1'b1;
        for (int i = 1; i <= 65537; i++) begin
            s_new_pc = 4'($urandom);
            tick();
            if (i == 65534) check("sat_minus1", s_count, 16'hFFFE);
        end
        check("sat_max", s_count, 16'hFFFF);
        check("sat_valid", s_if_valid, 1'b0);
        s_load = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
